// File: rtl/conv_pkg.sv
// Shared sizing constants and controller state encoding for the convolution
// scheduler and its window address helper.
package conv_pkg;

  localparam int CONV_DW      = 32;
  localparam int CONV_IMG_DIM = 5;
  localparam int CONV_K_DIM   = 3;
  localparam int CONV_OUT_DIM = CONV_IMG_DIM - CONV_K_DIM + 1;

  localparam int CONV_IMG_N = CONV_IMG_DIM * CONV_IMG_DIM;
  localparam int CONV_K_N   = CONV_K_DIM * CONV_K_DIM;
  localparam int CONV_OUT_N = CONV_OUT_DIM * CONV_OUT_DIM;

  localparam int CONV_IMG_IW = $clog2(CONV_IMG_N);
  localparam int CONV_K_IW   = $clog2(CONV_K_N);
  localparam int CONV_O_IW   = $clog2(CONV_OUT_N + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/conv_sched_ctrl_win_addr.sv
// Combinational window address math: maps (output position, kernel tap) to
// the flat image element index and the flat kernel element index.
module conv_win_addr
  import conv_pkg::*;
#(
  parameter int IMG_DIM = CONV_IMG_DIM,
  parameter int K_DIM   = CONV_K_DIM,
  parameter int OW      = CONV_O_IW,
  parameter int TW      = CONV_K_IW,
  parameter int IW      = CONV_IMG_IW
) (
  input  logic [OW-1:0] o_i,
  input  logic [TW-1:0] t_i,
  output logic [IW-1:0] img_idx_o,
  output logic [TW-1:0] ker_idx_o
);

  localparam int OUT_DIM = IMG_DIM - K_DIM + 1;

  int o_row, o_col, k_row, k_col;

  always_comb begin
    o_row     = int'(o_i) / OUT_DIM;
    o_col     = int'(o_i) % OUT_DIM;
    k_row     = int'(t_i) / K_DIM;
    k_col     = int'(t_i) % K_DIM;
    img_idx_o = IW'((o_row + k_row) * IMG_DIM + (o_col + k_col));
    ker_idx_o = t_i;
  end

endmodule

// File: rtl/conv_sched_ctrl.sv
// Sequences a 2-D valid convolution through one shared external fp MAC:
// latches operands, streams (image, kernel) beats, and collects the results.
module conv_sched_ctrl
  import conv_pkg::*;
#(
  parameter int DW      = CONV_DW,
  parameter int IMG_DIM = CONV_IMG_DIM,
  parameter int K_DIM   = CONV_K_DIM
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   start,
  input  logic [DW*IMG_DIM*IMG_DIM-1:0]          image,
  input  logic [DW*K_DIM*K_DIM-1:0]              kernal,
  output logic                                   busy,
  output logic                                   done,
  output logic [DW*(IMG_DIM-K_DIM+1)*(IMG_DIM-K_DIM+1)-1:0] res,
  output logic [DW-1:0]                          mac_a,
  output logic [DW-1:0]                          mac_b,
  output logic                                   mac_valid,
  output logic                                   mac_first,
  output logic                                   mac_last,
  input  logic                                   mac_ready,
  input  logic [DW-1:0]                          mac_res,
  input  logic                                   mac_res_valid
);

  localparam int OUT_DIM = IMG_DIM - K_DIM + 1;
  localparam int IMG_N   = IMG_DIM * IMG_DIM;
  localparam int K_N     = K_DIM * K_DIM;
  localparam int OUT_N   = OUT_DIM * OUT_DIM;
  localparam int IW      = $clog2(IMG_N);
  localparam int TW      = $clog2(K_N);
  localparam int OW      = $clog2(OUT_N + 1);

  state_e        state_q, state_d;
  logic [OW-1:0] o_q, o_d;
  logic [TW-1:0] t_q, t_d;
  logic [OW-1:0] w_q, w_d;
  logic [DW-1:0] img_q [IMG_N];
  logic [DW-1:0] ker_q [K_N];
  logic [DW-1:0] res_q [OUT_N];

  logic          load;
  logic          beat;
  logic          cap;
  logic          issuing;
  logic [IW-1:0] img_idx;
  logic [TW-1:0] ker_idx;

  conv_win_addr #(
    .IMG_DIM (IMG_DIM),
    .K_DIM   (K_DIM),
    .OW      (OW),
    .TW      (TW),
    .IW      (IW)
  ) u_win_addr (
    .o_i       (o_q),
    .t_i       (t_q),
    .img_idx_o (img_idx),
    .ker_idx_o (ker_idx)
  );

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    t_d     = t_q;
    w_d     = w_q;
    load    = 1'b0;
    beat    = (state_q == S_ISSUE) && mac_ready;
    // Results are only meaningful while a run is in flight and slots remain.
    cap     = ((state_q == S_ISSUE) || (state_q == S_DRAIN)) && mac_res_valid &&
              (w_q != OW'(OUT_N));
    if (cap) w_d = w_q + OW'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          o_d     = '0;
          t_d     = '0;
          w_d     = '0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (beat) begin
          if (t_q == TW'(K_N - 1)) begin
            t_d = '0;
            if (o_q == OW'(OUT_N - 1)) state_d = S_DRAIN;
            else                       o_d     = o_q + OW'(1);
          end else begin
            t_d = t_q + TW'(1);
          end
        end
      end
      S_DRAIN: begin
        if (w_d == OW'(OUT_N)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      o_q     <= '0;
      t_q     <= '0;
      w_q     <= '0;
      for (int i = 0; i < IMG_N; i++) img_q[i] <= '0;
      for (int i = 0; i < K_N; i++)   ker_q[i] <= '0;
      for (int i = 0; i < OUT_N; i++) res_q[i] <= '0;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
      t_q     <= t_d;
      w_q     <= w_d;
      if (load) begin
        for (int i = 0; i < IMG_N; i++) img_q[i] <= image[DW*(IMG_N-1-i) +: DW];
        for (int i = 0; i < K_N; i++)   ker_q[i] <= kernal[DW*(K_N-1-i) +: DW];
      end
      for (int i = 0; i < OUT_N; i++) begin
        if (load)                          res_q[i] <= '0;
        else if (cap && (w_q == OW'(i)))   res_q[i] <= mac_res;
      end
    end
  end

  // Beat outputs follow the held counters, so a stall keeps them stable.
  assign issuing   = (state_q == S_ISSUE);
  assign busy      = issuing || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign mac_valid = issuing;
  assign mac_first = issuing && (t_q == '0);
  assign mac_last  = issuing && (t_q == TW'(K_N - 1));
  assign mac_a     = issuing ? img_q[img_idx] : '0;
  assign mac_b     = issuing ? ker_q[ker_idx] : '0;

  for (genvar gi = 0; gi < OUT_N; gi++) begin : g_res
    assign res[DW*(OUT_N-1-gi) +: DW] = res_q[gi];
  end

endmodule

// File: tb/tb_conv_sched_ctrl.sv
// Self-checking bench for conv_sched_ctrl: a mock MAC with configurable
// latency and random backpressure, checked against a loop-nest reference.
module tb_conv_sched_ctrl;

  localparam int DW = 32, IMG_DIM = 5, K_DIM = 3, OUT_DIM = 3;
  localparam int IMG_N = 25, K_N = 9, OUT_N = 9, NBEATS = 81;
  localparam int IMGW = DW*IMG_N, KERW = DW*K_N, RESW = DW*OUT_N;

  logic            clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [IMGW-1:0] image = '0;
  logic [KERW-1:0] kernal = '0;
  logic            busy, done, mac_valid, mac_first, mac_last;
  logic [RESW-1:0] res;
  logic [DW-1:0]   mac_a, mac_b;
  logic            mac_ready = 1'b0, mac_res_valid = 1'b0;
  logic [DW-1:0]   mac_res = '0;

  always #5 clk = ~clk;

  conv_sched_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .image(image), .kernal(kernal),
    .busy(busy), .done(done), .res(res), .mac_a(mac_a), .mac_b(mac_b),
    .mac_valid(mac_valid), .mac_first(mac_first), .mac_last(mac_last),
    .mac_ready(mac_ready), .mac_res(mac_res), .mac_res_valid(mac_res_valid)
  );

  int errors = 0, checks = 0;

  logic [DW-1:0] obs_a[$], obs_b[$], exp_a[$], exp_b[$];
  bit            obs_f[$], obs_l[$], exp_f[$], exp_l[$];
  int  done_cnt, drain_cnt, stall_bad, res_cyc, done_cyc, first_beat_cyc, last_beat_cyc;
  bit  timed_out, aborted, first_busy, first_valid, busy_at_done;
  logic [RESW-1:0] res_at_done, res_end, snap_res, exp_res;
  logic snap_valid, snap_busy;
  logic [IMGW-1:0] nom_img;
  logic [KERW-1:0] nom_ker;

  function automatic logic [IMGW-1:0] rand_img();
    logic [IMGW-1:0] v;
    for (int k = 0; k < IMG_N; k++) v[DW*(IMG_N-1-k) +: DW] = $urandom;
    return v;
  endfunction

  function automatic logic [KERW-1:0] rand_ker();
    logic [KERW-1:0] v;
    for (int k = 0; k < K_N; k++) v[DW*(K_N-1-k) +: DW] = $urandom;
    return v;
  endfunction

  // Reference beat stream: loop nest over output row/col then kernel row/col.
  task automatic build_expected(input logic [IMGW-1:0] img, input logic [KERW-1:0] ker);
    exp_a.delete(); exp_b.delete(); exp_f.delete(); exp_l.delete();
    for (int orow = 0; orow < OUT_DIM; orow++)
      for (int ocol = 0; ocol < OUT_DIM; ocol++)
        for (int kr = 0; kr < K_DIM; kr++)
          for (int kc = 0; kc < K_DIM; kc++) begin
            int ii, kk;
            ii = (orow + kr) * IMG_DIM + (ocol + kc);
            kk = kr * K_DIM + kc;
            exp_a.push_back(img[DW*(IMG_N-1-ii) +: DW]);
            exp_b.push_back(ker[DW*(K_N-1-kk) +: DW]);
            exp_f.push_back(kr == 0 && kc == 0);
            exp_l.push_back(kr == K_DIM-1 && kc == K_DIM-1);
          end
    for (int w = 0; w < OUT_N; w++) exp_res[DW*(OUT_N-1-w) +: DW] = DW'(32'h1000 + w);
  endtask

  function automatic int beat_mismatches();
    int n = 0;
    for (int i = 0; i < obs_a.size() && i < exp_a.size(); i++)
      if (obs_a[i] !== exp_a[i] || obs_b[i] !== exp_b[i] ||
          obs_f[i] !== exp_f[i] || obs_l[i] !== exp_l[i]) n++;
    return n;
  endfunction

  // Drives one run with a mock MAC; optionally injects a start while busy or a reset.
  task automatic run_conv(input logic [IMGW-1:0] img, input logic [KERW-1:0] ker,
                          input int lat, input int stall_pct, input int sb_beat,
                          input logic [IMGW-1:0] img2, input int rst_beat);
    int beats, outs, rets, post;
    int due_q[$];
    logic [DW-1:0] tag_q[$];
    bit have_prev, sb_sent;
    logic [2*DW+1:0] prev;
    obs_a.delete(); obs_b.delete(); obs_f.delete(); obs_l.delete();
    done_cnt = 0; drain_cnt = 0; stall_bad = 0; res_cyc = -1; done_cyc = -1;
    first_beat_cyc = -1; last_beat_cyc = -1;
    timed_out = 1; aborted = 0; busy_at_done = 1;
    beats = 0; outs = 0; rets = 0; post = -1; have_prev = 0; sb_sent = 0; prev = '0;
    @(negedge clk);
    image = img; kernal = ker; start = 1'b1; mac_ready = 1'b0; mac_res_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; first_busy = busy; first_valid = mac_valid;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      start = 1'b0;
      if (rst_beat >= 0 && beats == rst_beat) begin
        rst = 1'b1;
        #1;
        snap_valid = mac_valid; snap_busy = busy; snap_res = res;
        aborted = 1; timed_out = 0; mac_ready = 1'b0; mac_res_valid = 1'b0;
        return;
      end
      if (sb_beat >= 0 && !sb_sent && beats == sb_beat) begin
        start = 1'b1; image = img2; sb_sent = 1;
      end
      mac_ready = ($urandom_range(99) >= stall_pct);
      mac_res_valid = 1'b0; mac_res = '0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
        due_q.delete(0);
        mac_res = tag_q.pop_front(); mac_res_valid = 1'b1;
        rets++;
        if (rets == OUT_N) res_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc = cyc; res_at_done = res; busy_at_done = busy; post = 4;
        end
      end
      if (busy && !mac_valid) drain_cnt++;
      if (mac_valid) begin
        if (have_prev && {mac_a, mac_b, mac_first, mac_last} !== prev) stall_bad++;
        if (mac_ready) begin
          obs_a.push_back(mac_a); obs_b.push_back(mac_b);
          obs_f.push_back(mac_first); obs_l.push_back(mac_last);
          if (first_beat_cyc < 0) first_beat_cyc = cyc;
          last_beat_cyc = cyc;
          if (mac_last) begin
            due_q.push_back(cyc + lat);
            tag_q.push_back(DW'(32'h1000 + outs));
            outs++;
          end
          beats++; have_prev = 0;
        end else begin
          have_prev = 1; prev = {mac_a, mac_b, mac_first, mac_last};
        end
      end else begin
        if (have_prev) stall_bad++;
        have_prev = 0;
      end
      if (post == 0) begin timed_out = 0; break; end
      if (post > 0) post--;
      @(negedge clk);
    end
    mac_ready = 1'b0; mac_res_valid = 1'b0;
    res_end = res;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, done, mac_valid, mac_first, mac_last, mac_a, mac_b} !== '0 || res !== '0) begin
      errors++; $display("FAIL reset_state: busy=%b done=%b valid=%b a=%h res_nz=%b, want all 0",
                         busy, done, mac_valid, mac_a, |res);
    end
    image = rand_img(); kernal = rand_ker(); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mac_valid !== 1'b1) begin
      errors++; $display("FAIL reset_prestart: busy=%b valid=%b, want 1 1", busy, mac_valid);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({busy, done, mac_valid, mac_first, mac_last, mac_a, mac_b} !== '0 || res !== '0) begin
      errors++; $display("FAIL reset_async: busy=%b valid=%b first=%b a=%h b=%h, want all 0",
                         busy, mac_valid, mac_first, mac_a, mac_b);
    end
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mac_res_valid = 1'b1; mac_res = $urandom | 32'h1;
      @(negedge clk);
      checks++;
      if (res !== '0 || done !== 1'b0) begin
        errors++; $display("FAIL idle_res_ignored: res_nz=%b done=%b, want 0 0", |res, done);
      end
    end
    mac_res_valid = 1'b0;
    $display("reset: idle checks complete");
  endtask

  task automatic test_nominal();
    int nb;
    nom_img = rand_img();
    nom_img[DW*(IMG_N-1-0)  +: DW] = 32'h3dcccccd;
    nom_img[DW*(IMG_N-1-1)  +: DW] = 32'h3ecccccd;
    nom_img[DW*(IMG_N-1-12) +: DW] = 32'h3f51eb85;
    nom_img[DW*(IMG_N-1-24) +: DW] = 32'h3ef5c28f;
    nom_ker = rand_ker();
    nom_ker[DW*(K_N-1-0) +: DW] = 32'h3fc00000;
    nom_ker[DW*(K_N-1-8) +: DW] = 32'h3f000000;
    build_expected(nom_img, nom_ker);
    run_conv(nom_img, nom_ker, 4, 0, -1, '0, -1);
    $display("nominal: beats=%0d done_pulses=%0d drain=%0d", obs_a.size(), done_cnt, drain_cnt);
    checks++;
    if (timed_out) begin errors++; $display("FAIL nominal_timeout: done=0, want done pulse"); end
    checks++;
    if (first_busy !== 1'b1 || first_valid !== 1'b1) begin
      errors++; $display("FAIL nominal_first_cycle: busy=%b valid=%b, want 1 1", first_busy, first_valid);
    end
    nb = beat_mismatches();
    checks++;
    if (obs_a.size() != NBEATS || nb != 0) begin
      errors++; $display("FAIL nominal_beats: got %0d beats %0d wrong, want %0d beats 0 wrong", obs_a.size(), nb, NBEATS);
    end
    checks++;
    if (obs_a.size() < 10 || obs_a[0] !== 32'h3dcccccd || obs_b[0] !== 32'h3fc00000 ||
        obs_f[0] !== 1'b1 || obs_l[0] !== 1'b0) begin
      errors++; $display("FAIL nominal_beat0: a=%h b=%h, want 3dcccccd 3fc00000 first", obs_a[0], obs_b[0]);
    end
    checks++;
    if (obs_a.size() < 10 || obs_a[8] !== 32'h3f51eb85 || obs_b[8] !== 32'h3f000000 || obs_l[8] !== 1'b1) begin
      errors++; $display("FAIL nominal_beat8: a=%h b=%h, want 3f51eb85 3f000000 last", obs_a[8], obs_b[8]);
    end
    checks++;
    if (obs_a.size() < 10 || obs_a[9] !== 32'h3ecccccd || obs_f[9] !== 1'b1) begin
      errors++; $display("FAIL nominal_beat9: a=%h first=%b, want 3ecccccd 1", obs_a[9], obs_f[9]);
    end
    checks++;
    if (last_beat_cyc - first_beat_cyc != NBEATS - 1) begin
      errors++; $display("FAIL nominal_throughput: span=%0d, want %0d", last_beat_cyc - first_beat_cyc, NBEATS - 1);
    end
    checks++;
    if (done_cnt != 1 || busy_at_done !== 1'b0) begin
      errors++; $display("FAIL nominal_done: pulses=%0d busy=%b, want 1 0", done_cnt, busy_at_done);
    end
    checks++;
    if (done_cyc != res_cyc + 1) begin
      errors++; $display("FAIL nominal_done_latency: done_cyc=%0d, want %0d", done_cyc, res_cyc + 1);
    end
    checks++;
    if (res_at_done !== exp_res || res_end !== exp_res) begin
      errors++; $display("FAIL nominal_res: got %h, want %h", res_at_done, exp_res);
    end
  endtask

  task automatic test_backpressure();
    int nb;
    build_expected(nom_img, nom_ker);
    run_conv(nom_img, nom_ker, 4, 30, -1, '0, -1);
    nb = beat_mismatches();
    $display("backpressure: beats=%0d done_pulses=%0d stall_bad=%0d", obs_a.size(), done_cnt, stall_bad);
    checks++;
    if (obs_a.size() != NBEATS || nb != 0) begin
      errors++; $display("FAIL bp_beats: got %0d beats %0d wrong, want %0d beats 0 wrong", obs_a.size(), nb, NBEATS);
    end
    checks++;
    if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_stable: changes=%0d, want 0", stall_bad); end
    checks++;
    if (done_cnt != 1 || res_at_done !== exp_res) begin
      errors++; $display("FAIL bp_done_res: pulses=%0d res=%h, want 1 %h", done_cnt, res_at_done, exp_res);
    end
  endtask

  task automatic test_results_during_issue();
    int nb;
    logic [IMGW-1:0] img;
    logic [KERW-1:0] ker;
    img = rand_img(); ker = rand_ker();
    build_expected(img, ker);
    run_conv(img, ker, 1, 0, -1, '0, -1);
    nb = beat_mismatches();
    $display("results_during_issue: beats=%0d drain=%0d done_pulses=%0d", obs_a.size(), drain_cnt, done_cnt);
    checks++;
    if (obs_a.size() != NBEATS || nb != 0) begin
      errors++; $display("FAIL rdi_beats: got %0d beats %0d wrong, want %0d beats 0 wrong", obs_a.size(), nb, NBEATS);
    end
    checks++;
    if (drain_cnt > 1) begin errors++; $display("FAIL rdi_drain: cycles=%0d, want <=1", drain_cnt); end
    checks++;
    if (done_cnt != 1 || res_at_done !== exp_res) begin
      errors++; $display("FAIL rdi_done_res: pulses=%0d res=%h, want 1 %h", done_cnt, res_at_done, exp_res);
    end
  endtask

  task automatic test_start_while_busy();
    int nb;
    logic [IMGW-1:0] img;
    logic [KERW-1:0] ker;
    img = rand_img(); ker = rand_ker();
    build_expected(img, ker);
    run_conv(img, ker, 4, 0, 20, rand_img(), -1);
    nb = beat_mismatches();
    $display("start_while_busy: beats=%0d done_pulses=%0d", obs_a.size(), done_cnt);
    checks++;
    if (obs_a.size() != NBEATS || nb != 0) begin
      errors++; $display("FAIL swb_beats: got %0d beats %0d wrong, want %0d beats 0 wrong", obs_a.size(), nb, NBEATS);
    end
    checks++;
    if (done_cnt != 1 || res_at_done !== exp_res) begin
      errors++; $display("FAIL swb_done_res: pulses=%0d res=%h, want 1 %h", done_cnt, res_at_done, exp_res);
    end
  endtask

  task automatic test_reset_midop();
    int nb;
    logic [IMGW-1:0] img;
    logic [KERW-1:0] ker;
    img = rand_img(); ker = rand_ker();
    run_conv(img, ker, 4, 0, -1, '0, 40);
    checks++;
    if (aborted !== 1'b1 || snap_valid !== 1'b0 || snap_busy !== 1'b0 || snap_res !== '0) begin
      errors++; $display("FAIL midop_reset: aborted=%b valid=%b busy=%b res_nz=%b, want 1 0 0 0",
                         aborted, snap_valid, snap_busy, |snap_res);
    end
    @(negedge clk); rst = 1'b0;
    img = rand_img(); ker = rand_ker();
    build_expected(img, ker);
    run_conv(img, ker, 4, 0, -1, '0, -1);
    nb = beat_mismatches();
    $display("reset_midop: restart beats=%0d done_pulses=%0d", obs_a.size(), done_cnt);
    checks++;
    if (obs_a.size() != NBEATS || nb != 0) begin
      errors++; $display("FAIL midop_restart_beats: got %0d beats %0d wrong, want %0d beats 0 wrong", obs_a.size(), nb, NBEATS);
    end
    checks++;
    if (done_cnt != 1 || res_at_done !== exp_res) begin
      errors++; $display("FAIL midop_restart_res: pulses=%0d res=%h, want 1 %h", done_cnt, res_at_done, exp_res);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_results_during_issue();
    test_start_while_busy();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/conv_sched_ctrl.md
Name: conv_sched_ctrl

Overview:
- Sequences one 2-D valid convolution of a packed float32 image with a packed float32 kernel through a single shared external floating-point MAC unit.
- Latches the operands on start, then walks every output position and kernel tap, issuing one operand pair per beat.
- Collects the accumulated results into a packed result bus and pulses done.
- Sits between the host/DMA-side operand registers and the fp MAC in the super-resolution conv path.

Parameters:
- DW, 32, element width (IEEE-754 single).
- IMG_DIM, 5, image side length.
- K_DIM, 3, kernel side length.
- OUT_DIM (localparam), IMG_DIM-K_DIM+1 = 3, output side length.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- image  in  DW*IMG_DIM*IMG_DIM  packed image; element k=5r+c at bits [DW*(N-1-k) +: DW] (element 0 at MSB).
- kernal  in  DW*K_DIM*K_DIM  packed kernel, same MSB-first packing.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when all results are captured.
- res  out  DW*OUT_DIM*OUT_DIM  packed results, MSB-first.
- mac_a  out  DW  image operand.
- mac_b  out  DW  kernel operand.
- mac_valid  out  1  operand beat valid.
- mac_first  out  1  first tap of an output position; MAC clears its accumulator.
- mac_last  out  1  last tap of an output position; MAC emits a result after it.
- mac_ready  in  1  MAC accepts the beat.
- mac_res  in  DW  accumulated result.
- mac_res_valid  in  1  mac_res valid, one cycle per output, in issue order.

Behaviour:
- Reset, asynchronous: state=IDLE; busy=0, done=0, mac_valid=0, mac_first=0, mac_last=0, mac_a=0, mac_b=0, res=0; all counters 0.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: on start=1, latch image and kernal, clear res to 0, zero the counters, go to ISSUE. Operand inputs are ignored after latching.
- ISSUE:
  - busy=1; mac_valid=1 on the first ISSUE cycle.
  - Counters: o (0..OUT_DIM²-1), t (0..K_DIM²-1).
  - Mapping: or=o/OUT_DIM, oc=o%OUT_DIM, kr=t/K_DIM, kc=t%K_DIM.
  - Operands: mac_a = image element (or+kr)*IMG_DIM+(oc+kc); mac_b = kernel element t.
  - Flags: mac_first=(t==0), mac_last=(t==K_DIM²-1).
  - Advance on mac_valid&&mac_ready: t increments; on wrap, t=0 and o increments.
  - Stall: with mac_ready=0, mac_a/mac_b/mac_first/mac_last/mac_valid hold stable (no beat dropped or repeated).
  - After the final beat (o=8, t=8) is accepted: mac_valid=0 next cycle, go to DRAIN.
  - Throughput with mac_ready=1: 81 beats in 81 consecutive cycles.
- Result capture (any of ISSUE/DRAIN):
  - Each mac_res_valid writes mac_res to res element w, then w increments.
  - Results may arrive while still issuing.
  - mac_res_valid in IDLE/DONE, or with w==OUT_DIM², is ignored.
- DRAIN: when w reaches OUT_DIM² (including the same cycle the 9th result is written), go to DONE.
- DONE: done=1 and busy=0 for exactly one cycle; res holds; next state IDLE.
- Hold after completion: res holds until the next accepted start.
- start while busy or in DONE: ignored, not queued.
- Reset mid-operation: immediate abort to reset values. The MAC must also be reset by the same rst.
- Latency: start accepted at edge E → first beat valid after E → done at the cycle after the edge that captures the 9th result.

Decomposition:
- Package conv_pkg: DW, IMG_DIM, K_DIM, OUT_DIM, index widths (clog2), FSM state encoding.
- One sub-module: conv_win_addr. Combinational (o,t) → image index and kernel index, so the address math is unit-testable separately.

Test Plan:
- Reset/idle: assert rst mid-cycle with no clk edge → all outputs 0 immediately. Pulse mac_res_valid in IDLE → res stays 0, done never pulses.
- Nominal run:
  - Stimulus: image=800'h3dcccccd3ecccccd…3ef5c28f, kernal=288'h3fc00000…3f000000; mac_ready=1; mock MAC with 4-cycle latency returning tag 0x1000+o.
  - Beat 0: a=0x3dcccccd, b=0x3fc00000, first=1.
  - Beat 8: a=0x3f51eb85, b=0x3f000000, last=1.
  - Beat 9: a=0x3ecccccd, first=1.
  - Exactly 81 beats; done pulses once; res = 0x1000..0x1008 MSB-first.
- Backpressure: same run with mac_ready random at 30% → beat sequence identical to the nominal run; operands stable on every stalled cycle; done pulses once.
- Results during issue: mock MAC latency 1 → results interleave with issuing; res correct; DRAIN lasts ≤1 cycle.
- Start while busy: pulse start at beat 20 with a different image → ignored; outputs match the nominal run.
- Reset mid-op: assert rst at beat 40 → mac_valid=0, busy=0, res=0 immediately. A fresh start then produces a full, correct 81-beat run.
